// File: rtl/pd_stage_nw.sv
// pd_stage_nw: predicts one FETCH_WIDTH-wide fetch block per cycle from a gshare PHT
// and a tagged direct-mapped BTB. It keeps a ring of GHR checkpoints so a redirect can
// restore the history of any in-flight block. Blocks go to decode over valid/ready.
module pd_stage_nw #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     FETCH_WIDTH = 4,
    parameter int unsigned     PHT_ADDRESS = 9,
    parameter int unsigned     GHR_SIZE    = 9,
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter int unsigned     CKPT_DEPTH  = 8,
    parameter int unsigned     CKPT_ADDR   = $clog2(CKPT_DEPTH),
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic                               CLK,
    input  logic                               reset,
    input  logic                               pd_ready,
    input  logic                               mispredict,
    input  logic [CKPT_ADDR-1:0]               mp_ckpt_id,
    input  logic                               ex_is_branch,
    input  logic                               actual_taken,
    input  logic [XLEN-1:0]                    actual_target_address,
    input  logic                               update_pht,
    input  logic [PHT_ADDRESS-1:0]             rb_pht_index,
    input  logic                               update_btb,
    input  logic [XLEN-1:0]                    ex_pc,
    input  logic                               ex_is_jump,
    input  logic                               commit_ckpt,
    output logic                               pd_valid,
    output logic [XLEN-1:0]                    pd_pc,
    output logic [FETCH_WIDTH-1:0]             pd_slot_valid,
    output logic [FETCH_WIDTH-1:0]             pd_pred_taken,
    output logic [XLEN-1:0]                    pd_pred_target,
    output logic [FETCH_WIDTH*PHT_ADDRESS-1:0] pd_pht_index,
    output logic [GHR_SIZE-1:0]                pd_prev_ghr,
    output logic [CKPT_ADDR-1:0]               pd_ckpt_id
);

    localparam int unsigned     BTB_IDX_W   = $clog2(BTB_ENTRIES);
    localparam int unsigned     TAG_W       = XLEN - BTB_IDX_W - 2;
    localparam int unsigned     PHT_ENTRIES = 2 ** PHT_ADDRESS;
    localparam logic [XLEN-1:0] BLOCK_BYTES = XLEN'(FETCH_WIDTH * 4);
    localparam logic [XLEN-1:0] BLOCK_MASK  = ~(BLOCK_BYTES - 1'b1);

    logic [XLEN-1:0]      pc_q;
    logic [GHR_SIZE-1:0]  ghr_q;
    logic [1:0]           pht_q        [PHT_ENTRIES];
    logic                 btb_valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0]     btb_tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]      btb_target_q [BTB_ENTRIES];
    logic                 btb_jump_q   [BTB_ENTRIES];
    logic [GHR_SIZE-1:0]  ckpt_q       [CKPT_DEPTH];
    logic [CKPT_ADDR-1:0] head_q, tail_q, head_d, tail_d, tail_inc;
    logic                 full_q, full_d;

    logic [XLEN-1:0]        base, target;
    logic [XLEN-1:0]        slot_addr [FETCH_WIDTH];
    logic [PHT_ADDRESS-1:0] pidx      [FETCH_WIDTH];
    logic [BTB_IDX_W-1:0]   bidx      [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] slot_valid, pred_taken, hit;
    logic [FETCH_WIDTH*PHT_ADDRESS-1:0] pht_index;
    logic [GHR_SIZE-1:0]    ghr_next, ghr_redirect, ckpt_sel;
    logic                   found, cond_seen, win_cond, load, commit_en;
    logic                   unused_bits;

    assign unused_bits = ^ex_pc[1:0];

    // Per-slot lookup; the lowest taken slot at or after the entry offset wins.
    always_comb begin
        base       = pc_q & BLOCK_MASK;
        target     = base + BLOCK_BYTES;
        slot_valid = '0;
        pred_taken = '0;
        hit        = '0;
        pht_index  = '0;
        found      = 1'b0;
        cond_seen  = 1'b0;
        win_cond   = 1'b0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            slot_addr[i] = base + XLEN'(4 * i);
            pidx[i]      = PHT_ADDRESS'(ghr_q) ^ slot_addr[i][PHT_ADDRESS+1:2];
            bidx[i]      = slot_addr[i][BTB_IDX_W+1:2];
            pht_index[i*PHT_ADDRESS +: PHT_ADDRESS] = pidx[i];
            hit[i] = btb_valid_q[bidx[i]] &&
                     (btb_tag_q[bidx[i]] == slot_addr[i][XLEN-1:BTB_IDX_W+2]);
            if (!found && (slot_addr[i][XLEN-1:2] >= pc_q[XLEN-1:2])) begin
                slot_valid[i] = 1'b1;
                if (hit[i] && !btb_jump_q[bidx[i]]) begin
                    cond_seen = 1'b1;
                end
                // Counter MSB set means the counter is 2 or 3.
                if (hit[i] && (btb_jump_q[bidx[i]] || pht_q[pidx[i]][1])) begin
                    found         = 1'b1;
                    pred_taken[i] = 1'b1;
                    target        = btb_target_q[bidx[i]];
                    win_cond      = !btb_jump_q[bidx[i]];
                end
            end
        end
        ghr_next = cond_seen ? ((ghr_q << 1) | GHR_SIZE'(win_cond)) : ghr_q;
    end

    // Handshake and checkpoint ring pointers; redirect rewinds tail after commit moves head.
    always_comb begin
        load         = (!pd_valid || pd_ready) && !full_q && !mispredict;
        commit_en    = commit_ckpt && (full_q || (head_q != tail_q));
        head_d       = commit_en ? head_q + 1'b1 : head_q;
        tail_inc     = tail_q + 1'b1;
        ckpt_sel     = ckpt_q[mp_ckpt_id];
        ghr_redirect = ex_is_branch ? ((ckpt_sel << 1) | GHR_SIZE'(actual_taken)) : ckpt_sel;
        tail_d       = tail_q;
        full_d       = full_q;
        if (mispredict) begin
            tail_d = mp_ckpt_id + 1'b1;
            // Equal pointers after a rewind only stay full if the newest block mispredicted.
            full_d = full_q && !commit_en && (tail_d == head_d);
        end else begin
            if (load) begin
                tail_d = tail_inc;
            end
            if (commit_en) begin
                full_d = 1'b0;
            end else if (load) begin
                full_d = (tail_inc == head_q);
            end
        end
    end

    // Fetch PC, history, ring pointers and the output register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            pc_q           <= RESET_PC;
            ghr_q          <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            full_q         <= 1'b0;
            pd_valid       <= 1'b0;
            pd_pc          <= '0;
            pd_slot_valid  <= '0;
            pd_pred_taken  <= '0;
            pd_pred_target <= '0;
            pd_pht_index   <= '0;
            pd_prev_ghr    <= '0;
            pd_ckpt_id     <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            full_q <= full_d;
            if (mispredict) begin
                pd_valid <= 1'b0;
                pc_q     <= actual_target_address;
                ghr_q    <= ghr_redirect;
            end else if (load) begin
                pd_valid       <= 1'b1;
                pd_pc          <= pc_q;
                pd_slot_valid  <= slot_valid;
                pd_pred_taken  <= pred_taken;
                pd_pred_target <= target;
                pd_pht_index   <= pht_index;
                pd_prev_ghr    <= ghr_q;
                pd_ckpt_id     <= tail_q;
                pc_q           <= target;
                ghr_q          <= ghr_next;
            end else if (pd_ready) begin
                pd_valid <= 1'b0;
            end
        end
    end

    // Checkpoint storage: history as it was before each allocated block.
    always_ff @(posedge CLK) begin
        if (load) begin
            ckpt_q[tail_q] <= ghr_q;
        end
    end

    // PHT training with saturating 2-bit counters.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= 2'b01;
            end
        end else if (update_pht) begin
            if (actual_taken && (pht_q[rb_pht_index] != 2'b11)) begin
                pht_q[rb_pht_index] <= pht_q[rb_pht_index] + 2'd1;
            end else if (!actual_taken && (pht_q[rb_pht_index] != 2'b00)) begin
                pht_q[rb_pht_index] <= pht_q[rb_pht_index] - 2'd1;
            end
        end
    end

    // BTB valid bits.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[i] <= 1'b0;
            end
        end else if (update_btb) begin
            btb_valid_q[ex_pc[BTB_IDX_W+1:2]] <= 1'b1;
        end
    end

    // BTB payload; only meaningful behind a valid bit so it needs no reset.
    always_ff @(posedge CLK) begin
        if (update_btb) begin
            btb_tag_q[ex_pc[BTB_IDX_W+1:2]]    <= ex_pc[XLEN-1:BTB_IDX_W+2];
            btb_target_q[ex_pc[BTB_IDX_W+1:2]] <= actual_target_address;
            btb_jump_q[ex_pc[BTB_IDX_W+1:2]]   <= ex_is_jump;
        end
    end

endmodule

// File: tb/tb_pd_stage_nw.sv
// Bench for pd_stage_nw: directed stimulus, a block-level reference model checked on
// every cycle, plus literal expectations at key points of each scenario.
module tb_pd_stage_nw;

    logic        CLK = 1'b0;
    logic        reset, pd_ready, mispredict, ex_is_branch, actual_taken;
    logic [2:0]  mp_ckpt_id;
    logic [31:0] actual_target_address, ex_pc;
    logic        update_pht, update_btb, ex_is_jump, commit_ckpt;
    logic [8:0]  rb_pht_index;
    logic        pd_valid;
    logic [31:0] pd_pc, pd_pred_target;
    logic [3:0]  pd_slot_valid, pd_pred_taken;
    logic [35:0] pd_pht_index;
    logic [8:0]  pd_prev_ghr;
    logic [2:0]  pd_ckpt_id;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    pd_stage_nw dut (
        .CLK                   (CLK),
        .reset                 (reset),
        .pd_ready              (pd_ready),
        .mispredict            (mispredict),
        .mp_ckpt_id            (mp_ckpt_id),
        .ex_is_branch          (ex_is_branch),
        .actual_taken          (actual_taken),
        .actual_target_address (actual_target_address),
        .update_pht            (update_pht),
        .rb_pht_index          (rb_pht_index),
        .update_btb            (update_btb),
        .ex_pc                 (ex_pc),
        .ex_is_jump            (ex_is_jump),
        .commit_ckpt           (commit_ckpt),
        .pd_valid              (pd_valid),
        .pd_pc                 (pd_pc),
        .pd_slot_valid         (pd_slot_valid),
        .pd_pred_taken         (pd_pred_taken),
        .pd_pred_target        (pd_pred_target),
        .pd_pht_index          (pd_pht_index),
        .pd_prev_ghr           (pd_prev_ghr),
        .pd_ckpt_id            (pd_ckpt_id)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    int          m_ghr, m_head, m_count;
    int          m_pht [512];
    bit          m_btb_v [16];
    bit          m_btb_j [16];
    logic [31:0] m_btb_tag [16];
    logic [31:0] m_btb_tgt [16];
    int          m_ckpt [8];
    bit          e_valid;
    logic [31:0] e_pc, e_tgt;
    logic [3:0]  e_slot, e_taken;
    logic [35:0] e_pht;
    int          e_prev, e_id;

    task automatic model_reset();
        m_pc = 32'h0; m_ghr = 0; m_head = 0; m_count = 0;
        for (int i = 0; i < 512; i++) m_pht[i] = 1;
        for (int i = 0; i < 16; i++) m_btb_v[i] = 1'b0;
        e_valid = 1'b0; e_pc = '0; e_tgt = '0; e_slot = '0; e_taken = '0;
        e_pht = '0; e_prev = 0; e_id = 0;
    endtask

    task automatic model_edge();
        logic [31:0] base, a, tgt, wtgt;
        logic [35:0] pidx;
        logic [3:0]  smask, tmask;
        int          off, win, last, pi, bi, nghr, tail, g, rb;
        bit          cond_any, win_cond, ld, cm;
        bit          hit [4];
        bit          jmp [4];
        base = m_pc & ~32'hF;
        off  = int'((m_pc >> 2) & 32'd3);
        pidx = '0; win = -1; wtgt = '0;
        for (int i = 0; i < 4; i++) begin
            a  = base + 32'(4 * i);
            pi = int'(((a >> 2) ^ 32'(m_ghr)) & 32'd511);
            pidx[i*9 +: 9] = pi[8:0];
            bi = int'((a >> 2) & 32'd15);
            hit[i] = m_btb_v[bi] && (m_btb_tag[bi] == (a >> 6));
            jmp[i] = m_btb_j[bi];
            if (win < 0 && i >= off && hit[i] && (jmp[i] || m_pht[pi] >= 2)) begin
                win = i; wtgt = m_btb_tgt[bi];
            end
        end
        last  = (win < 0) ? 3 : win;
        tgt   = (win < 0) ? base + 32'd16 : wtgt;
        tmask = (win < 0) ? 4'b0 : (4'b1 << win);
        smask = '0; cond_any = 1'b0;
        for (int i = off; i <= last; i++) begin
            smask[i] = 1'b1;
            if (hit[i] && !jmp[i]) cond_any = 1'b1;
        end
        win_cond = (win >= 0) && !jmp[last];
        nghr = cond_any ? (((m_ghr << 1) | int'(win_cond)) & 511) : m_ghr;
        ld = (!e_valid || pd_ready) && (m_count < 8) && !mispredict;
        cm = commit_ckpt && (m_count > 0);
        if (mispredict) begin
            g = m_ckpt[mp_ckpt_id];
            m_ghr = ex_is_branch ? (((g << 1) | int'(actual_taken)) & 511) : g;
            // Entries from head up to the mispredicted one survive.
            m_count = ((int'(mp_ckpt_id) - m_head + 8) % 8) + 1 - int'(cm);
            m_head  = (m_head + int'(cm)) % 8;
            e_valid = 1'b0;
            m_pc    = actual_target_address;
        end else begin
            if (ld) begin
                tail = (m_head + m_count) % 8;
                m_ckpt[tail] = m_ghr;
                e_valid = 1'b1; e_pc = m_pc; e_slot = smask; e_taken = tmask;
                e_tgt = tgt; e_pht = pidx; e_prev = m_ghr; e_id = tail;
                m_ghr = nghr; m_pc = tgt; m_count++;
            end else if (pd_ready) begin
                e_valid = 1'b0;
            end
            if (cm) begin
                m_head = (m_head + 1) % 8; m_count--;
            end
        end
        if (update_pht) begin
            rb = int'(rb_pht_index);
            if (actual_taken) begin
                if (m_pht[rb] < 3) m_pht[rb]++;
            end else if (m_pht[rb] > 0) begin
                m_pht[rb]--;
            end
        end
        if (update_btb) begin
            bi = int'((ex_pc >> 2) & 32'd15);
            m_btb_v[bi] = 1'b1; m_btb_tag[bi] = ex_pc >> 6;
            m_btb_tgt[bi] = actual_target_address; m_btb_j[bi] = ex_is_jump;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge reset);
            if (!reset) model_reset();
            else model_edge();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge CLK);
            check("valid", 64'(pd_valid), 64'(e_valid));
            check("pc", 64'(pd_pc), 64'(e_pc));
            check("slot_valid", 64'(pd_slot_valid), 64'(e_slot));
            check("pred_taken", 64'(pd_pred_taken), 64'(e_taken));
            check("pred_target", 64'(pd_pred_target), 64'(e_tgt));
            check("pht_index", 64'(pd_pht_index), 64'(e_pht));
            check("prev_ghr", 64'(pd_prev_ghr), 64'(e_prev));
            check("ckpt_id", 64'(pd_ckpt_id), 64'(e_id));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        mispredict = 0; mp_ckpt_id = '0; ex_is_branch = 0; actual_taken = 0;
        actual_target_address = '0; update_pht = 0; rb_pht_index = '0;
        update_btb = 0; ex_pc = '0; ex_is_jump = 0; commit_ckpt = 0; pd_ready = 1;
    endtask

    task automatic pulse_reset();
        reset = 0;
        idle_inputs();
        tick();
        tick();
        reset = 1;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        #1 reset = 0;
        tick();
        tick();
        check("rst_valid", 64'(pd_valid), 64'h0);
        check("rst_pc", 64'(pd_pc), 64'h0);

        // Sequential blocks with an empty BTB.
        reset = 1; commit_ckpt = 1;
        tick();
        check("t1_pc0", 64'(pd_pc), 64'h0);
        check("t1_slots", 64'(pd_slot_valid), 64'hF);
        check("t1_taken", 64'(pd_pred_taken), 64'h0);
        check("t1_id0", 64'(pd_ckpt_id), 64'h0);
        tick();
        check("t1_pc1", 64'(pd_pc), 64'h10);
        check("t1_id1", 64'(pd_ckpt_id), 64'h1);
        tick();
        check("t1_pc2", 64'(pd_pc), 64'h20);
        check("t1_ghr", 64'(pd_prev_ghr), 64'h0);

        // Jump in slot 1 of block 0x10.
        pulse_reset();
        update_btb = 1; ex_pc = 32'h14; actual_target_address = 32'h100; ex_is_jump = 1;
        tick();
        idle_inputs();
        check("t2_pc0", 64'(pd_pc), 64'h0);
        tick();
        check("t2_slots", 64'(pd_slot_valid), 64'h3);
        check("t2_taken", 64'(pd_pred_taken), 64'h2);
        check("t2_target", 64'(pd_pred_target), 64'h100);
        tick();
        check("t2_pc_next", 64'(pd_pc), 64'h100);

        // Conditional branch at 0x8, trained up then down; redirects hold the fetch at 0.
        pulse_reset();
        tick();
        mispredict = 1; mp_ckpt_id = 0;
        update_btb = 1; ex_pc = 32'h8; actual_target_address = 32'h40; ex_is_jump = 0;
        update_pht = 1; rb_pht_index = 9'd2; actual_taken = 1;
        tick();
        update_btb = 0; actual_target_address = 32'h0;
        check("t3_bubble", 64'(pd_valid), 64'h0);
        tick();
        idle_inputs();
        tick();
        check("t3_slots_t", 64'(pd_slot_valid), 64'h7);
        check("t3_taken_t", 64'(pd_pred_taken), 64'h4);
        check("t3_target_t", 64'(pd_pred_target), 64'h40);
        check("t3_id", 64'(pd_ckpt_id), 64'h1);
        tick();
        check("t3_pc40", 64'(pd_pc), 64'h40);
        check("t3_ghr1", 64'(pd_prev_ghr), 64'h1);
        mispredict = 1; mp_ckpt_id = 0; update_pht = 1; rb_pht_index = 9'd2;
        tick();
        idle_inputs();
        tick();
        check("t3_taken_w", 64'(pd_pred_taken), 64'h4);
        mispredict = 1; mp_ckpt_id = 0; update_pht = 1; rb_pht_index = 9'd2;
        tick();
        idle_inputs();
        tick();
        check("t3_taken_n", 64'(pd_pred_taken), 64'h0);
        check("t3_slots_n", 64'(pd_slot_valid), 64'hF);
        check("t3_target_n", 64'(pd_pred_target), 64'h10);
        tick();
        check("t3_ghr0", 64'(pd_prev_ghr), 64'h0);

        // Stall at 0x40, then fill all checkpoints and release one.
        pulse_reset();
        repeat (5) tick();
        check("t4_pc40", 64'(pd_pc), 64'h40);
        pd_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_hold_pc", 64'(pd_pc), 64'h40);
            check("t4_hold_v", 64'(pd_valid), 64'h1);
        end
        pd_ready = 1;
        tick();
        check("t4_pc50", 64'(pd_pc), 64'h50);
        tick();
        tick();
        check("t4_pc70", 64'(pd_pc), 64'h70);
        check("t4_id7", 64'(pd_ckpt_id), 64'h7);
        tick();
        check("t4_full_v", 64'(pd_valid), 64'h0);
        tick();
        check("t4_full_v2", 64'(pd_valid), 64'h0);
        commit_ckpt = 1;
        tick();
        commit_ckpt = 0;
        check("t4_commit_v", 64'(pd_valid), 64'h0);
        tick();
        check("t4_pc80", 64'(pd_pc), 64'h80);
        check("t4_wrap_id", 64'(pd_ckpt_id), 64'h0);

        // Redirect to checkpoint 2 with a taken branch.
        pulse_reset();
        repeat (6) tick();
        check("t5_id5", 64'(pd_ckpt_id), 64'h5);
        mispredict = 1; mp_ckpt_id = 3'd2; ex_is_branch = 1; actual_taken = 1;
        actual_target_address = 32'h200;
        tick();
        idle_inputs();
        check("t5_bubble", 64'(pd_valid), 64'h0);
        tick();
        check("t5_pc", 64'(pd_pc), 64'h200);
        check("t5_id", 64'(pd_ckpt_id), 64'h3);
        check("t5_ghr", 64'(pd_prev_ghr), 64'h1);
        check("t5_pht0", 64'(pd_pht_index[8:0]), 64'h81);

        // Commit and redirect together at count 1, then reset during a stall.
        pulse_reset();
        pd_ready = 0;
        tick();
        check("t6_pc0", 64'(pd_pc), 64'h0);
        commit_ckpt = 1; mispredict = 1; mp_ckpt_id = 0; actual_target_address = 32'h300;
        tick();
        idle_inputs();
        pd_ready = 0;
        check("t6_bubble", 64'(pd_valid), 64'h0);
        tick();
        check("t6_pc300", 64'(pd_pc), 64'h300);
        check("t6_id1", 64'(pd_ckpt_id), 64'h1);
        tick();
        check("t6_stall", 64'(pd_pc), 64'h300);
        reset = 0;
        #1;
        check("t6_rst_v", 64'(pd_valid), 64'h0);
        check("t6_rst_pc", 64'(pd_pc), 64'h0);
        tick();
        reset = 1;
        tick();
        check("t6_restart_pc", 64'(pd_pc), 64'h0);
        check("t6_restart_id", 64'(pd_ckpt_id), 64'h0);
        check("t6_restart_v", 64'(pd_valid), 64'h1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
